fpu_ss_core_arbiter: RTL and testbench

- Sits directly upstream of the shared FPU subsystem wrapper and fans NB_CORES core-side X-interfaces into its single issue port.
- Issue side: round-robin arbitration with grant lock during backpressure; the granted core's index drives the subsystem's core_id_i.
- Result side: a one-entry registered buffer steers each result to the core named by the subsystem's dest_core_id_o.
- Compressed, commit and memory interfaces are routed by separate logic and are not handled here.

---
 rtl/fpu_ss_pkg.sv | 37 +++
 rtl/fpu_ss_rr_arbiter.sv | 66 ++++++
 rtl/fpu_ss_core_arbiter.sv | 95 +++++++++
 tb/tb_fpu_ss_core_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_ss_pkg.sv
// Shared FPU subsystem types plus the helpers used by the per-core arbitration front end.
package fpu_ss_pkg;

  localparam int unsigned NB_CORES_MAX = 32;

  typedef struct packed {
    logic [31:0]      instr;
    logic [1:0]       mode;
    logic [3:0]       id;
    logic [1:0][31:0] rs;
    logic [1:0]       rs_valid;
  } x_issue_req_t;

  typedef struct packed {
    logic accept;
    logic writeback;
    logic dualwrite;
    logic dualread;
    logic loadstore;
    logic exc;
  } x_issue_resp_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [4:0]  rd;
    logic        we;
    logic        exc;
    logic [5:0]  exccode;
  } x_result_t;

  // Next round-robin pointer after serving index ptr out of n requesters.
  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
    return (ptr >= n - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/fpu_ss_rr_arbiter.sv
// Generic N-way round-robin arbiter; the grant is frozen while the downstream stalls.
module fpu_ss_rr_arbiter
  import fpu_ss_pkg::*;
#(
  parameter int unsigned N = 8,
  localparam int unsigned IDX_W = $clog2(N)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N-1:0]     req_i,
  input  logic             hold_i,       // granted request offered but not taken
  input  logic             handshake_i,  // granted request taken
  output logic [IDX_W-1:0] gnt_idx_o,
  output logic             gnt_valid_o
);

  logic [IDX_W-1:0] rr_ptr_q;
  logic [IDX_W-1:0] locked_idx_q;
  logic             lock_q;
  logic [IDX_W-1:0] search_gnt;

  // Find the first active request at or after the round-robin pointer.
  always_comb begin
    int unsigned      pos;
    logic [IDX_W-1:0] pos_idx;
    logic             found;
    search_gnt = '0;
    found      = 1'b0;
    pos        = 0;
    pos_idx    = '0;
    for (int unsigned k = 0; k < N; k++) begin
      pos = 32'(rr_ptr_q) + k;
      if (pos >= N) pos = pos - N;
      pos_idx = IDX_W'(pos);
      if (!found && req_i[pos_idx]) begin
        found      = 1'b1;
        search_gnt = pos_idx;
      end
    end
  end

  // A held grant overrides the search until its handshake.
  always_comb begin
    gnt_idx_o   = lock_q ? locked_idx_q : search_gnt;
    gnt_valid_o = lock_q ? req_i[locked_idx_q] : |req_i;
  end

  // Pointer advances past the served requester; lock follows the stall condition.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr_q     <= '0;
      lock_q       <= 1'b0;
      locked_idx_q <= '0;
    end else begin
      // A dropped request produces no stall, so the lock also releases on that violation.
      lock_q <= hold_i;
      if (hold_i) locked_idx_q <= gnt_idx_o;
      if (handshake_i) rr_ptr_q <= IDX_W'(rr_next(32'(gnt_idx_o), N));
    end
  end

  a_locked_req_held: assert property (@(posedge clk_i) disable iff (rst_i)
    lock_q |-> req_i[locked_idx_q])
    else $error("locked requester dropped its valid before handshake");

endmodule

// File: rtl/fpu_ss_core_arbiter.sv
// Fans NB_CORES core X-interfaces into one fpu_ss issue port and steers results back.
module fpu_ss_core_arbiter
  import fpu_ss_pkg::*;
#(
  parameter int unsigned NB_CORES = 8,
  localparam int unsigned IDX_W = $clog2(NB_CORES)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NB_CORES-1:0]          core_issue_valid_i,
  output logic [NB_CORES-1:0]          core_issue_ready_o,
  input  x_issue_req_t [NB_CORES-1:0]  core_issue_req_i,
  output x_issue_resp_t [NB_CORES-1:0] core_issue_resp_o,
  output logic                         fpu_issue_valid_o,
  input  logic                         fpu_issue_ready_i,
  output x_issue_req_t                 fpu_issue_req_o,
  input  x_issue_resp_t                fpu_issue_resp_i,
  output logic [31:0]                  fpu_core_id_o,
  input  logic                         fpu_result_valid_i,
  output logic                         fpu_result_ready_o,
  input  x_result_t                    fpu_result_i,
  input  logic [31:0]                  fpu_dest_core_id_i,
  output logic [NB_CORES-1:0]          core_result_valid_o,
  input  logic [NB_CORES-1:0]          core_result_ready_i,
  output x_result_t                    core_result_o,
  output logic                         route_err_o
);

  logic [IDX_W-1:0] gnt;
  logic             gnt_valid;

  logic             buf_valid_q;
  x_result_t        buf_data_q;
  logic [IDX_W-1:0] buf_dest_q;
  logic             route_err_q;

  logic drain;
  logic accept;
  logic in_range;

  fpu_ss_rr_arbiter #(
    .N (NB_CORES)
  ) u_rr_arbiter (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_i       (core_issue_valid_i),
    .hold_i      (gnt_valid && !fpu_issue_ready_i),
    .handshake_i (gnt_valid && fpu_issue_ready_i),
    .gnt_idx_o   (gnt),
    .gnt_valid_o (gnt_valid)
  );

  // Zero-latency issue mux: only the granted core sees ready and response.
  always_comb begin
    fpu_issue_valid_o       = gnt_valid;
    fpu_issue_req_o         = core_issue_req_i[gnt];
    fpu_core_id_o           = 32'(gnt);
    core_issue_ready_o      = '0;
    core_issue_ready_o[gnt] = fpu_issue_ready_i;
    core_issue_resp_o       = '0;
    core_issue_resp_o[gnt]  = fpu_issue_resp_i;
  end

  // Result buffer handshake; a full buffer still accepts when it drains this cycle.
  always_comb begin
    drain              = buf_valid_q && core_result_ready_i[buf_dest_q];
    fpu_result_ready_o = !buf_valid_q || drain;
    accept             = fpu_result_valid_i && fpu_result_ready_o;
    in_range           = fpu_dest_core_id_i < NB_CORES;
    core_result_valid_o             = '0;
    core_result_valid_o[buf_dest_q] = buf_valid_q;
    core_result_o      = buf_data_q;
    route_err_o        = route_err_q;
  end

  // One-entry result buffer; misrouted results are swallowed and flagged.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      buf_valid_q <= 1'b0;
      buf_data_q  <= '0;
      buf_dest_q  <= '0;
      route_err_q <= 1'b0;
    end else begin
      route_err_q <= accept && !in_range;
      if (accept && in_range) begin
        buf_valid_q <= 1'b1;
        buf_data_q  <= fpu_result_i;
        buf_dest_q  <= fpu_dest_core_id_i[IDX_W-1:0];
      end else if (drain) begin
        buf_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fpu_ss_core_arbiter.sv
// Directed bench for the core-to-fpu_ss arbiter with NB_CORES = 8.
module tb_fpu_ss_core_arbiter;
  import fpu_ss_pkg::*;

  localparam int unsigned NC = 8;

  logic                   clk;
  logic                   rst;
  logic [NC-1:0]          core_issue_valid;
  logic [NC-1:0]          core_issue_ready;
  x_issue_req_t [NC-1:0]  core_issue_req;
  x_issue_resp_t [NC-1:0] core_issue_resp;
  logic                   fpu_issue_valid;
  logic                   fpu_issue_ready;
  x_issue_req_t           fpu_issue_req;
  x_issue_resp_t          fpu_issue_resp;
  logic [31:0]            fpu_core_id;
  logic                   fpu_result_valid;
  logic                   fpu_result_ready;
  x_result_t              fpu_result;
  logic [31:0]            fpu_dest_core_id;
  logic [NC-1:0]          core_result_valid;
  logic [NC-1:0]          core_result_ready;
  x_result_t              core_result;
  logic                   route_err;

  int checks;
  int failures;

  fpu_ss_core_arbiter #(
    .NB_CORES (NC)
  ) dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .core_issue_valid_i  (core_issue_valid),
    .core_issue_ready_o  (core_issue_ready),
    .core_issue_req_i    (core_issue_req),
    .core_issue_resp_o   (core_issue_resp),
    .fpu_issue_valid_o   (fpu_issue_valid),
    .fpu_issue_ready_i   (fpu_issue_ready),
    .fpu_issue_req_o     (fpu_issue_req),
    .fpu_issue_resp_i    (fpu_issue_resp),
    .fpu_core_id_o       (fpu_core_id),
    .fpu_result_valid_i  (fpu_result_valid),
    .fpu_result_ready_o  (fpu_result_ready),
    .fpu_result_i        (fpu_result),
    .fpu_dest_core_id_i  (fpu_dest_core_id),
    .core_result_valid_o (core_result_valid),
    .core_result_ready_i (core_result_ready),
    .core_result_o       (core_result),
    .route_err_o         (route_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; checks happen at the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    core_issue_valid  = '0;
    core_issue_req    = '0;
    fpu_issue_ready   = 1'b0;
    fpu_issue_resp    = '0;
    fpu_result_valid  = 1'b0;
    fpu_result        = '0;
    fpu_dest_core_id  = '0;
    core_result_ready = '0;
    for (int i = 0; i < NC; i++) core_issue_req[i].instr = 32'h100 + i;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (fpu_issue_valid !== 1'b0) begin
      failures++; $display("FAIL reset_issue_valid: got %0b expected 0", fpu_issue_valid);
    end
    checks++;
    if (core_issue_ready !== 8'h00) begin
      failures++; $display("FAIL reset_issue_ready: got %0h expected 0", core_issue_ready);
    end
    checks++;
    if (core_result_valid !== 8'h00) begin
      failures++; $display("FAIL reset_result_valid: got %0h expected 0", core_result_valid);
    end
    checks++;
    if (fpu_result_ready !== 1'b1) begin
      failures++; $display("FAIL reset_result_ready: got %0b expected 1", fpu_result_ready);
    end
    checks++;
    if (fpu_core_id !== 32'd0) begin
      failures++; $display("FAIL reset_core_id: got %0d expected 0", fpu_core_id);
    end
    checks++;
    if (route_err !== 1'b0 || core_result !== '0) begin
      failures++; $display("FAIL reset_err_payload: got err=%0b data=%0h expected 0/0",
                           route_err, core_result.data);
    end
    tick();
  endtask

  task automatic test_round_robin();
    int exp_g[4] = '{2, 5, 7, 2};
    core_issue_valid = 8'b1010_0100;
    fpu_issue_ready  = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (fpu_core_id !== 32'(exp_g[c])) begin
        failures++; $display("FAIL rr_grant[%0d]: got %0d expected %0d", c, fpu_core_id, exp_g[c]);
      end
      checks++;
      if (fpu_issue_req.instr !== 32'h100 + 32'(exp_g[c])) begin
        failures++; $display("FAIL rr_req[%0d]: got %0h expected %0h", c, fpu_issue_req.instr,
                             32'h100 + exp_g[c]);
      end
      checks++;
      if (core_issue_ready !== 8'(1 << exp_g[c]) || fpu_issue_valid !== 1'b1) begin
        failures++; $display("FAIL rr_ready[%0d]: got %0h/%0b expected %0h/1", c, core_issue_ready,
                             fpu_issue_valid, 8'(1 << exp_g[c]));
      end
      tick();
    end
    // Pointer now sits at 3; serve core 0 to move it to 1.
    core_issue_valid = 8'h01;
    @(negedge clk);
    checks++;
    if (fpu_core_id !== 32'd0) begin
      failures++; $display("FAIL rr_wrap_to0: got %0d expected 0", fpu_core_id);
    end
    tick();
    core_issue_valid = '0;
    fpu_issue_ready  = 1'b0;
  endtask

  task automatic test_lock();
    // Pointer is 1: without the lock, core 1 would win once it raises valid.
    core_issue_valid = 8'h08;
    for (int c = 1; c <= 4; c++) begin
      if (c == 2) core_issue_valid = 8'h0A;
      @(negedge clk);
      checks++;
      if (fpu_core_id !== 32'd3 || fpu_issue_valid !== 1'b1 || core_issue_ready !== 8'h00) begin
        failures++; $display("FAIL lock_hold[%0d]: got id=%0d v=%0b rdy=%0h expected 3/1/0", c,
                             fpu_core_id, fpu_issue_valid, core_issue_ready);
      end
      tick();
    end
    fpu_issue_ready       = 1'b1;
    fpu_issue_resp.accept = 1'b1;
    @(negedge clk);
    checks++;
    if (fpu_core_id !== 32'd3 || core_issue_ready !== 8'h08) begin
      failures++; $display("FAIL lock_release: got id=%0d rdy=%0h expected 3/08", fpu_core_id,
                           core_issue_ready);
    end
    checks++;
    if (core_issue_resp[3].accept !== 1'b1 || core_issue_resp[1] !== '0) begin
      failures++; $display("FAIL lock_resp: got acc3=%0b resp1=%0h expected 1/0",
                           core_issue_resp[3].accept, core_issue_resp[1]);
    end
    tick();
    core_issue_valid = 8'h02;
    @(negedge clk);
    checks++;
    if (fpu_core_id !== 32'd1 || core_issue_ready !== 8'h02) begin
      failures++; $display("FAIL lock_next_wrap: got id=%0d rdy=%0h expected 1/02", fpu_core_id,
                           core_issue_ready);
    end
    tick();
    core_issue_valid = '0;
    fpu_issue_ready  = 1'b0;
    fpu_issue_resp   = '0;
  endtask

  task automatic test_result_stall();
    core_result_ready = '0;
    fpu_result_valid  = 1'b1;
    fpu_dest_core_id  = 32'd6;
    fpu_result.data   = 32'hA5;
    @(negedge clk);
    checks++;
    if (fpu_result_ready !== 1'b1) begin
      failures++; $display("FAIL stall_accept: got %0b expected 1", fpu_result_ready);
    end
    tick();
    fpu_result_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (core_result_valid !== 8'h40 || fpu_result_ready !== 1'b0 ||
          core_result.data !== 32'hA5) begin
        failures++; $display("FAIL stall_hold[%0d]: got v=%0h rdy=%0b d=%0h expected 40/0/a5", c,
                             core_result_valid, fpu_result_ready, core_result.data);
      end
      tick();
    end
    core_result_ready = 8'h40;
    @(negedge clk);
    checks++;
    if (fpu_result_ready !== 1'b1) begin
      failures++; $display("FAIL stall_drain_ready: got %0b expected 1", fpu_result_ready);
    end
    tick();
    @(negedge clk);
    checks++;
    if (core_result_valid !== 8'h00) begin
      failures++; $display("FAIL stall_cleared: got %0h expected 0", core_result_valid);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    core_result_ready = 8'hFF;
    fpu_result_valid  = 1'b1;
    fpu_dest_core_id  = 32'd1;
    fpu_result.data   = 32'h11;
    tick();
    fpu_dest_core_id = 32'd4;
    fpu_result.data  = 32'h44;
    @(negedge clk);
    checks++;
    if (core_result_valid !== 8'h02 || core_result.data !== 32'h11 || fpu_result_ready !== 1'b1) begin
      failures++; $display("FAIL b2b_first: got v=%0h d=%0h rdy=%0b expected 02/11/1",
                           core_result_valid, core_result.data, fpu_result_ready);
    end
    tick();
    fpu_result_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (core_result_valid !== 8'h10 || core_result.data !== 32'h44) begin
      failures++; $display("FAIL b2b_second: got v=%0h d=%0h expected 10/44",
                           core_result_valid, core_result.data);
    end
    tick();
    @(negedge clk);
    checks++;
    if (core_result_valid !== 8'h00) begin
      failures++; $display("FAIL b2b_empty: got %0h expected 0", core_result_valid);
    end
    tick();
  endtask

  task automatic test_route_err();
    fpu_result_valid = 1'b1;
    fpu_dest_core_id = 32'd9;
    fpu_result.data  = 32'h99;
    @(negedge clk);
    checks++;
    if (fpu_result_ready !== 1'b1 || route_err !== 1'b0) begin
      failures++; $display("FAIL err_accept: got rdy=%0b err=%0b expected 1/0", fpu_result_ready,
                           route_err);
    end
    tick();
    fpu_result_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (route_err !== 1'b1 || core_result_valid !== 8'h00) begin
      failures++; $display("FAIL err_pulse: got err=%0b v=%0h expected 1/0", route_err,
                           core_result_valid);
    end
    tick();
    @(negedge clk);
    checks++;
    if (route_err !== 1'b0) begin
      failures++; $display("FAIL err_one_cycle: got %0b expected 0", route_err);
    end
    tick();
  endtask

  task automatic test_reset_full_buffer();
    core_result_ready = '0;
    fpu_result_valid  = 1'b1;
    fpu_dest_core_id  = 32'd2;
    fpu_result.data   = 32'h22;
    tick();
    fpu_result_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (core_result_valid !== 8'h04) begin
      failures++; $display("FAIL rstbuf_loaded: got %0h expected 04", core_result_valid);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (core_result_valid !== 8'h00 || fpu_result_ready !== 1'b1 || core_result !== '0) begin
      failures++; $display("FAIL rstbuf_async_clear: got v=%0h rdy=%0b d=%0h expected 0/1/0",
                           core_result_valid, fpu_result_ready, core_result.data);
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (core_result_valid !== 8'h00) begin
      failures++; $display("FAIL rstbuf_after: got %0h expected 0", core_result_valid);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_round_robin();
    test_lock();
    test_result_stall();
    test_back_to_back();
    test_route_err();
    test_reset_full_buffer();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
